// File: rtl/wr_resp_master_collect.sv
// Per-master write-response collector: allocates txnid slots, buffers returned responses
// per slot and hands them back to the master round-robin over a valid/ready handshake.

package vector_cache_pkg;
  localparam int unsigned TXNID_WIDTH = 6;

  typedef struct packed {
    logic [TXNID_WIDTH-1:0] txnid;
    logic [1:0]             resp;
    logic [7:0]             data;
  } wr_resp_pld_t;
endpackage

module wr_resp_master_collect
  import vector_cache_pkg::*;
#(
  parameter int unsigned SRC_NUM   = 4,
  parameter int unsigned SLOT_W    = 2,
  parameter int unsigned SLOT_NUM  = 4,
  parameter int unsigned MASTER_ID = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic         [SRC_NUM-1:0]       in_vld,
  input  wr_resp_pld_t [SRC_NUM-1:0]       in_pld,
  output logic                             alloc_vld,
  output logic         [TXNID_WIDTH-1:0]   alloc_txnid,
  input  logic                             alloc_take,
  output logic                             resp_vld,
  output wr_resp_pld_t                     resp_pld,
  input  logic                             resp_rdy,
  output logic         [SLOT_W:0]          outstanding_cnt,
  output logic                             err_unexp,
  output logic                             err_id
);

  localparam int unsigned ID_W = TXNID_WIDTH - SLOT_W;

  typedef enum logic [1:0] {SlotFree, SlotOut, SlotPend} slot_state_e;

  slot_state_e       state_q [SLOT_NUM];
  slot_state_e       state_d [SLOT_NUM];
  wr_resp_pld_t      pld_q   [SLOT_NUM];
  wr_resp_pld_t      pld_d   [SLOT_NUM];
  logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [SLOT_W-1:0] lock_slot_q, lock_slot_d;
  logic              err_unexp_q, err_unexp_d;
  logic              err_id_q, err_id_d;

  logic [SLOT_W-1:0] alloc_slot;
  logic [SLOT_W-1:0] rr_slot;
  logic [SLOT_W-1:0] sel_slot;
  logic              pend_any;
  logic              hs;
  logic [SLOT_NUM-1:0] cap_vld;
  logic [SLOT_NUM-1:0] claimed;
  logic [SLOT_W-1:0] lane_slot;
  logic [SLOT_W:0]   cnt;

  // Descending scan so the lowest-index free slot is the one left standing.
  always_comb begin
    alloc_vld  = 1'b0;
    alloc_slot = '0;
    for (int s = int'(SLOT_NUM) - 1; s >= 0; s--) begin
      if (state_q[s] == SlotFree) begin
        alloc_vld  = 1'b1;
        alloc_slot = SLOT_W'(s);
      end
    end
  end

  assign alloc_txnid = {ID_W'(MASTER_ID), alloc_slot};

  // Round-robin search from rr_ptr; descending offset so the nearest pending slot wins.
  always_comb begin
    pend_any = 1'b0;
    rr_slot  = rr_ptr_q;
    for (int k = int'(SLOT_NUM) - 1; k >= 0; k--) begin
      if (state_q[rr_ptr_q + SLOT_W'(k)] == SlotPend) begin
        pend_any = 1'b1;
        rr_slot  = rr_ptr_q + SLOT_W'(k);
      end
    end
  end

  assign sel_slot = lock_q ? lock_slot_q : rr_slot;
  assign resp_vld = lock_q ? (state_q[lock_slot_q] == SlotPend) : pend_any;
  assign resp_pld = resp_vld ? pld_q[sel_slot] : '0;
  assign hs       = resp_vld & resp_rdy;

  // Lane capture: lowest id-matching lane claims a slot; later lanes on that slot are dropped.
  always_comb begin
    cap_vld     = '0;
    claimed     = '0;
    lane_slot   = '0;
    err_unexp_d = err_unexp_q;
    err_id_d    = err_id_q;
    for (int s = 0; s < int'(SLOT_NUM); s++) begin
      pld_d[s] = pld_q[s];
    end
    for (int i = 0; i < int'(SRC_NUM); i++) begin
      lane_slot = in_pld[i].txnid[SLOT_W-1:0];
      if (in_vld[i]) begin
        if (in_pld[i].txnid[TXNID_WIDTH-1:SLOT_W] != ID_W'(MASTER_ID)) begin
          err_id_d = 1'b1;
        end else if (claimed[lane_slot]) begin
          err_unexp_d = 1'b1;
        end else begin
          claimed[lane_slot] = 1'b1;
          if (state_q[lane_slot] == SlotOut) begin
            cap_vld[lane_slot] = 1'b1;
            pld_d[lane_slot]   = in_pld[i];
          end else begin
            err_unexp_d = 1'b1;
          end
        end
      end
    end
  end

  // The three transitions require different current states, so they never collide.
  always_comb begin
    for (int s = 0; s < int'(SLOT_NUM); s++) begin
      state_d[s] = state_q[s];
      if (alloc_take && alloc_vld && alloc_slot == SLOT_W'(s)) state_d[s] = SlotOut;
      if (cap_vld[s]) state_d[s] = SlotPend;
      if (hs && sel_slot == SLOT_W'(s)) state_d[s] = SlotFree;
    end
    rr_ptr_d    = hs ? sel_slot + SLOT_W'(1) : rr_ptr_q;
    lock_d      = resp_vld & ~resp_rdy;
    lock_slot_d = sel_slot;
  end

  always_comb begin
    cnt = '0;
    for (int s = 0; s < int'(SLOT_NUM); s++) begin
      if (state_q[s] != SlotFree) cnt = cnt + (SLOT_W+1)'(1);
    end
  end

  assign outstanding_cnt = cnt;
  assign err_unexp       = err_unexp_q;
  assign err_id          = err_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SLOT_NUM); s++) begin
        state_q[s] <= SlotFree;
        pld_q[s]   <= '0;
      end
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      err_unexp_q <= 1'b0;
      err_id_q    <= 1'b0;
    end else begin
      for (int s = 0; s < int'(SLOT_NUM); s++) begin
        state_q[s] <= state_d[s];
        pld_q[s]   <= pld_d[s];
      end
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      err_unexp_q <= err_unexp_d;
      err_id_q    <= err_id_d;
    end
  end

endmodule

// File: tb/tb_wr_resp_master_collect.sv
// Directed vector bench for wr_resp_master_collect: one table row per clock cycle,
// expected outputs sampled before the edge that applies the row's inputs.

module tb_wr_resp_master_collect;
  import vector_cache_pkg::*;

  logic                       clk;
  logic                       rst;
  logic         [3:0]         in_vld;
  wr_resp_pld_t [3:0]         in_pld;
  logic                       alloc_vld;
  logic         [5:0]         alloc_txnid;
  logic                       alloc_take;
  logic                       resp_vld;
  wr_resp_pld_t               resp_pld;
  logic                       resp_rdy;
  logic         [2:0]         outstanding_cnt;
  logic                       err_unexp;
  logic                       err_id;

  wr_resp_master_collect #(
    .SRC_NUM  (4),
    .SLOT_W   (2),
    .SLOT_NUM (4),
    .MASTER_ID(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_vld         (in_vld),
    .in_pld         (in_pld),
    .alloc_vld      (alloc_vld),
    .alloc_txnid    (alloc_txnid),
    .alloc_take     (alloc_take),
    .resp_vld       (resp_vld),
    .resp_pld       (resp_pld),
    .resp_rdy       (resp_rdy),
    .outstanding_cnt(outstanding_cnt),
    .err_unexp      (err_unexp),
    .err_id         (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      vld;
    logic [3:0][5:0] tid;
    logic            take;
    logic            rdy;
    logic            avld;
    logic [1:0]      aslot;
    logic            rvld;
    logic [5:0]      rtid;
    logic [7:0]      rdata;
    logic [2:0]      cnt;
    logic            eu;
    logic            ei;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic [3:0] vld, input logic [5:0] t0, input logic [5:0] t1,
                              input logic [5:0] t2, input logic [5:0] t3, input logic take,
                              input logic rdy, input logic avld, input logic [1:0] aslot,
                              input logic rvld, input logic [5:0] rtid, input logic [7:0] rdata,
                              input logic [2:0] cnt, input logic eu, input logic ei);
    vec_t v;
    v.vld   = vld;
    v.tid   = {t3, t2, t1, t0};
    v.take  = take;
    v.rdy   = rdy;
    v.avld  = avld;
    v.aslot = aslot;
    v.rvld  = rvld;
    v.rtid  = rtid;
    v.rdata = rdata;
    v.cnt   = cnt;
    v.eu    = eu;
    v.ei    = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    in_vld     = v.vld;
    alloc_take = v.take;
    resp_rdy   = v.rdy;
    for (int i = 0; i < 4; i++) begin
      in_pld[i].txnid = v.tid[i];
      in_pld[i].resp  = 2'b00;
      in_pld[i].data  = {2'(i), v.tid[i]};
    end
  endtask

  initial begin
    vec_t idle;
    n_tests = 0;
    n_fail  = 0;
    idle = mk(4'b0, 6'h0, 6'h0, 6'h0, 6'h0, 0, 0, 0, 0, 0, 6'h0, 8'h0, 0, 0, 0);
    drive(idle);
    rst = 1'b1;

    // vld  t0     t1     t2     t3     take rdy | avld aslot rvld rtid  rdata  cnt eu ei
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 0, 0, 6'h0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 1, 0, 6'h0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 2, 0, 6'h0, 8'h00, 2, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 3, 0, 6'h0, 8'h00, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 0, 0, 0, 6'h0, 8'h00, 4, 0, 0));
    // west -> slot 2, north -> slot 0 in one cycle
    vecs.push_back(mk(4'b1001, 6'h2, 6'h0, 6'h0, 6'h0, 0, 1, 0, 0, 0, 6'h0, 8'h00, 4, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 1, 0, 0, 1, 6'h0, 8'hC0, 4, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 1, 1, 0, 1, 6'h2, 8'h02, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 1, 1, 0, 0, 6'h0, 8'h00, 2, 0, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 2, 0, 6'h0, 8'h00, 3, 0, 0));
    // east and south both on slot 1: east wins
    vecs.push_back(mk(4'b0110, 6'h0, 6'h1, 6'h1, 6'h0, 0, 0, 0, 0, 0, 6'h0, 8'h00, 4, 0, 0));
    vecs.push_back(mk(4'b1001, 6'h3, 6'h0, 6'h0, 6'h0, 0, 0, 0, 0, 1, 6'h1, 8'h41, 4, 1, 0));
    // three pending, rdy held low: selection stays on slot 1
    for (int r = 0; r < 5; r++)
      vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 0, 0, 0, 1, 6'h1, 8'h41, 4, 1, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 1, 0, 0, 1, 6'h1, 8'h41, 4, 1, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 1, 1, 1, 1, 6'h3, 8'h03, 3, 1, 0));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 1, 1, 1, 1, 6'h0, 8'hC0, 2, 1, 0));
    // upper-bits mismatch on west
    vecs.push_back(mk(4'b0001, 6'h6, 6'h0, 6'h0, 6'h0, 0, 0, 1, 0, 0, 6'h0, 8'h00, 1, 1, 0));
    // alloc slot 0 with a same-cycle response to it: response dropped
    vecs.push_back(mk(4'b0100, 6'h0, 6'h0, 6'h0, 6'h0, 1, 0, 1, 0, 0, 6'h0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(4'b0010, 6'h0, 6'h2, 6'h0, 6'h0, 1, 0, 1, 1, 0, 6'h0, 8'h00, 2, 1, 1));
    vecs.push_back(mk(4'b0001, 6'h0, 6'h0, 6'h0, 6'h0, 0, 0, 1, 3, 1, 6'h2, 8'h42, 3, 1, 1));
    vecs.push_back(mk(4'b0000, 6'h0, 6'h0, 6'h0, 6'h0, 0, 0, 1, 3, 1, 6'h2, 8'h42, 3, 1, 1));

    repeat (2) @(negedge clk);
    #1;
    check("reset alloc_vld", 32'(alloc_vld), 32'd1);
    check("reset alloc_txnid", 32'(alloc_txnid), 32'd0);
    check("reset resp_vld", 32'(resp_vld), 32'd0);
    check("reset resp_pld", 32'(resp_pld), 32'd0);
    check("reset cnt", 32'(outstanding_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      drive(vecs[r]);
      #1;
      check($sformatf("r%0d alloc_vld", r), 32'(alloc_vld), 32'(vecs[r].avld));
      if (vecs[r].avld)
        check($sformatf("r%0d alloc_txnid", r), 32'(alloc_txnid), {28'h0, 2'b00, vecs[r].aslot});
      check($sformatf("r%0d resp_vld", r), 32'(resp_vld), 32'(vecs[r].rvld));
      if (vecs[r].rvld)
        check($sformatf("r%0d resp_pld", r), {18'h0, resp_pld.txnid, resp_pld.data},
              {18'h0, vecs[r].rtid, vecs[r].rdata});
      check($sformatf("r%0d cnt", r), 32'(outstanding_cnt), 32'(vecs[r].cnt));
      check($sformatf("r%0d err_unexp", r), 32'(err_unexp), 32'(vecs[r].eu));
      check($sformatf("r%0d err_id", r), 32'(err_id), 32'(vecs[r].ei));
    end

    // Asynchronous reset mid-cycle with two slots pending and the selection locked
    drive(idle);
    #1;
    rst = 1'b1;
    #1;
    check("async rst resp_vld", 32'(resp_vld), 32'd0);
    check("async rst resp_pld", 32'(resp_pld), 32'd0);
    check("async rst alloc_vld", 32'(alloc_vld), 32'd1);
    check("async rst alloc_txnid", 32'(alloc_txnid), 32'd0);
    check("async rst cnt", 32'(outstanding_cnt), 32'd0);
    check("async rst err_unexp", 32'(err_unexp), 32'd0);
    check("async rst err_id", 32'(err_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post rst resp_vld", 32'(resp_vld), 32'd0);
    check("post rst cnt", 32'(outstanding_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
